// File: rtl/aic3204_pkg.sv
// Shared types for the AIC3204 stereo frame path.
// Sample/frame layouts, pack FSM states and a saturating counter helper.
package aic3204_pkg;

    localparam int AIC3204_SAMPLE_W = 16;

    typedef logic signed [AIC3204_SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t left;
        sample_t right;
    } frame_t;

    typedef enum logic [2:0] {
        IDLE,
        POP_NW,
        WAIT_NW,
        POP_PW,
        WAIT_PW,
        HOLD
    } frame_state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/aic3204_slip_timer.sv
// Slip timer: loadable count-up counter, tc high while count == SLIP_TIMEOUT-1.
// Latency: count updates 1 cycle after load/inc; tc is combinational from count.
// Backpressure: none; the counter holds at terminal count until reloaded.
module aic3204_slip_timer #(
    parameter int SLIP_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        inc,
    output logic        tc
);

    localparam logic [15:0] TERM = 16'(SLIP_TIMEOUT - 1);

    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && (count != TERM)) begin
            count <= count + 16'd1;
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/aic3204_frame_pack.sv
// Pairs nw (left) and pw (right) FIFO samples into 32-bit frames; drops an orphan left on slip.
// Latency: 5 cycles from IDLE with both FIFOs non-empty to frame_valid; one frame per 5 cycles.
// Backpressure: frame held stable until frame_ready; no pops while a frame waits. AIC3204_FRAME_STATS_EN adds counters.
module aic3204_frame_pack
    import aic3204_pkg::*;
#(
    parameter int SLIP_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] nw_fifo_rd_data,
    input  logic        nw_fifo_rd_valid,
    output logic        nw_fifo_rd_en,
    input  logic        nw_fifo_empty,
    input  logic [15:0] pw_fifo_rd_data,
    input  logic        pw_fifo_rd_valid,
    output logic        pw_fifo_rd_en,
    input  logic        pw_fifo_empty,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        slip
`ifdef AIC3204_FRAME_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] slip_count,
    output logic [15:0] stray_count
`endif
);

    frame_state_e state;
    sample_t      left_q;
    frame_t       frame_q;
    logic         tmr_load;
    logic         tmr_inc;
    logic         tmr_tc;

    // Timer restarts when the left sample lands and counts only while pw is starved.
    assign tmr_load = (state == WAIT_NW) && nw_fifo_rd_valid;
    assign tmr_inc  = (state == POP_PW) && !pw_fifo_rd_en && pw_fifo_empty;

    aic3204_slip_timer #(
        .SLIP_TIMEOUT(SLIP_TIMEOUT)
    ) u_slip_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (16'd0),
        .inc      (tmr_inc),
        .tc       (tmr_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            nw_fifo_rd_en <= 1'b0;
            pw_fifo_rd_en <= 1'b0;
            frame_valid   <= 1'b0;
            frame_q       <= '0;
            left_q        <= '0;
            slip          <= 1'b0;
        end else begin
            slip <= 1'b0;
            case (state)
                IDLE: begin
                    if (!nw_fifo_empty) begin
                        nw_fifo_rd_en <= 1'b1;
                        state         <= POP_NW;
                    end
                end
                POP_NW: begin
                    nw_fifo_rd_en <= 1'b0;
                    state         <= WAIT_NW;
                end
                WAIT_NW: begin
                    if (nw_fifo_rd_valid) begin
                        left_q        <= sample_t'(nw_fifo_rd_data);
                        pw_fifo_rd_en <= !pw_fifo_empty;
                        state         <= POP_PW;
                    end else begin
                        state <= IDLE;
                    end
                end
                POP_PW: begin
                    // rd_en is registered, so a late pw arrival costs one extra cycle here.
                    if (pw_fifo_rd_en) begin
                        pw_fifo_rd_en <= 1'b0;
                        state         <= WAIT_PW;
                    end else if (!pw_fifo_empty) begin
                        pw_fifo_rd_en <= 1'b1;
                    end else if (tmr_tc) begin
                        slip   <= 1'b1;
                        left_q <= '0;
                        state  <= IDLE;
                    end
                end
                WAIT_PW: begin
                    if (pw_fifo_rd_valid) begin
                        frame_q     <= '{left: left_q, right: sample_t'(pw_fifo_rd_data)};
                        frame_valid <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        left_q <= '0;
                        state  <= IDLE;
                    end
                end
                HOLD: begin
                    if (frame_ready) begin
                        frame_valid <= 1'b0;
                        if (!nw_fifo_empty) begin
                            nw_fifo_rd_en <= 1'b1;
                            state         <= POP_NW;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign frame_data = frame_q;

`ifdef AIC3204_FRAME_STATS_EN
    logic       nw_stray;
    logic       pw_stray;
    logic [1:0] stray_inc;

    assign nw_stray  = nw_fifo_rd_valid && (state != WAIT_NW);
    assign pw_stray  = pw_fifo_rd_valid && (state != WAIT_PW);
    assign stray_inc = {1'b0, nw_stray} + {1'b0, pw_stray};

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= '0;
            slip_count  <= '0;
            stray_count <= '0;
        end else begin
            frame_count <= sat_add16(frame_count, {1'b0, frame_valid && frame_ready});
            slip_count  <= sat_add16(slip_count, {1'b0, slip});
            stray_count <= sat_add16(stray_count, stray_inc);
        end
    end
`endif

endmodule

// File: tb/tb_aic3204_frame_pack.sv
// Bench for aic3204_frame_pack: FIFO models, frame scoreboard, directed and random traffic.
module tb_aic3204_frame_pack;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] nw_fifo_rd_data;
    logic        nw_fifo_rd_valid;
    logic        nw_fifo_rd_en;
    logic        nw_fifo_empty;
    logic [15:0] pw_fifo_rd_data;
    logic        pw_fifo_rd_valid;
    logic        pw_fifo_rd_en;
    logic        pw_fifo_empty;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic        slip;
`ifdef AIC3204_FRAME_STATS_EN
    logic [15:0] frame_count;
    logic [15:0] slip_count;
    logic [15:0] stray_count;
`endif

    always #5 clk = ~clk;

    aic3204_frame_pack #(.SLIP_TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .nw_fifo_rd_data  (nw_fifo_rd_data),
        .nw_fifo_rd_valid (nw_fifo_rd_valid),
        .nw_fifo_rd_en    (nw_fifo_rd_en),
        .nw_fifo_empty    (nw_fifo_empty),
        .pw_fifo_rd_data  (pw_fifo_rd_data),
        .pw_fifo_rd_valid (pw_fifo_rd_valid),
        .pw_fifo_rd_en    (pw_fifo_rd_en),
        .pw_fifo_empty    (pw_fifo_empty),
        .frame_data       (frame_data),
        .frame_valid      (frame_valid),
        .frame_ready      (frame_ready),
        .slip             (slip)
`ifdef AIC3204_FRAME_STATS_EN
        ,
        .frame_count      (frame_count),
        .slip_count       (slip_count),
        .stray_count      (stray_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference state: sample queues per FIFO, expected frames in order.
    logic [15:0] nw_q[$];
    logic [15:0] pw_q[$];
    logic [31:0] exp_q[$];
    int          exp_idx = 0;
    int          hs_cyc[$];
    int          n_slip = 0;
    int          cyc = 0;
    int          inj_nw_req = 0;
    int          inj_pw_req = 0;

    // FIFO models: a pop accepted at a clock edge yields rd_valid for the following cycle.
    initial begin
        int  nw_done = 0;
        int  pw_done = 0;
        bit  pend_nw;
        bit  pend_pw;
        nw_fifo_rd_valid = 1'b0;
        pw_fifo_rd_valid = 1'b0;
        nw_fifo_rd_data  = '0;
        pw_fifo_rd_data  = '0;
        nw_fifo_empty    = 1'b1;
        pw_fifo_empty    = 1'b1;
        forever begin
            @(negedge clk);
            pend_nw = nw_fifo_rd_en && (nw_q.size() > 0);
            pend_pw = pw_fifo_rd_en && (pw_q.size() > 0);
            @(posedge clk);
            #1;
            nw_fifo_rd_valid = 1'b0;
            pw_fifo_rd_valid = 1'b0;
            if (pend_nw) begin
                nw_fifo_rd_valid = 1'b1;
                nw_fifo_rd_data  = nw_q.pop_front();
            end else if (inj_nw_req != nw_done) begin
                nw_done++;
                nw_fifo_rd_valid = 1'b1;
                nw_fifo_rd_data  = 16'hDEAD;
            end
            if (pend_pw) begin
                pw_fifo_rd_valid = 1'b1;
                pw_fifo_rd_data  = pw_q.pop_front();
            end else if (inj_pw_req != pw_done) begin
                pw_done++;
                pw_fifo_rd_valid = 1'b1;
                pw_fifo_rd_data  = 16'hBEEF;
            end
            nw_fifo_empty = (nw_q.size() == 0);
            pw_fifo_empty = (pw_q.size() == 0);
        end
    end

    // Monitor: scoreboard on handshakes, stall stability, pop-on-empty and slip tracking.
    initial begin
        bit          stall_prev = 0;
        logic [31:0] held = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                stall_prev = 0;
            end else begin
                if (nw_fifo_rd_en) check("nw_rden_empty", 32'(nw_fifo_empty), 32'd0);
                if (pw_fifo_rd_en) check("pw_rden_empty", 32'(pw_fifo_empty), 32'd0);
                if (stall_prev) begin
                    check("hold_valid", 32'(frame_valid), 32'd1);
                    check("hold_data", frame_data, held);
                end
                if (frame_valid && frame_ready) begin
                    if (exp_idx >= exp_q.size()) begin
                        check("frame_unexp", 32'(frame_valid), 32'd0);
                    end else begin
                        check("frame_data", frame_data, exp_q[exp_idx]);
                        exp_idx++;
                    end
                    hs_cyc.push_back(cyc);
                end
                stall_prev = frame_valid && !frame_ready;
                held       = frame_data;
                if (slip) n_slip++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        nw_q.push_back(l);
        pw_q.push_back(r);
        exp_q.push_back({l, r});
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_idx < exp_q.size()) && (n < budget)) begin
            tick();
            n++;
        end
        check("drain_left", 32'(exp_q.size() - exp_idx), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        int frames_at_rst;
        int slip_at_rst;
        logic [15:0] l;

        reset       = 1'b1;
        frame_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", frame_data, 32'd0);
        check("rst_rden", {30'd0, nw_fifo_rd_en, pw_fifo_rd_en}, 32'd0);
        check("rst_slip", 32'(slip), 32'd0);

        // First frame: valid exactly 5 cycles after the first non-reset edge.
        push_pair(16'h1234, 16'hABCD);
        tick();
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("lat_valid_%0d", k), 32'(frame_valid), 32'(k == 6));
        end
        check("first_slip", 32'(n_slip), 32'd0);
        wait_drain(20);

        // Back-to-back stream of 8 pairs at one frame per 5 cycles.
        base = hs_cyc.size();
        for (int i = 0; i < 8; i++) push_pair(16'(i), 16'(16'h8000 + i));
        wait_drain(100);
        for (int i = 1; i < 8; i++)
            check($sformatf("thruput_%0d", i), 32'(hs_cyc[base + i] - hs_cyc[base + i - 1]), 32'd5);

        // Backpressure: frame held 20 cycles with no pops, then the next pop follows the handshake.
        frame_ready = 1'b0;
        push_pair(16'h0A0A, 16'h0B0B);
        push_pair(16'h0C0C, 16'h0D0D);
        n = 0;
        while (!frame_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_valid_seen", 32'(frame_valid), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("bp_no_rden", {30'd0, nw_fifo_rd_en, pw_fifo_rd_en}, 32'd0);
        end
        frame_ready = 1'b1;
        tick();
        check("bp_next_pop", 32'(nw_fifo_rd_en), 32'd1);
        wait_drain(30);

        // Reset while in WAIT_PW: outputs return to reset values, the half-frame is lost.
        nw_q.push_back(16'h5555);
        pw_q.push_back(16'h6666);
        n = 0;
        while (!pw_fifo_rd_en && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid_seen_pop", 32'(pw_fifo_rd_en), 32'd1);
        tick();
        reset = 1'b1;
        frames_at_rst = hs_cyc.size();
        slip_at_rst   = n_slip;
        tick();
        check("rst_mid_valid", 32'(frame_valid), 32'd0);
        check("rst_mid_data", frame_data, 32'd0);
        check("rst_mid_rden", {30'd0, nw_fifo_rd_en, pw_fifo_rd_en}, 32'd0);
        check("rst_mid_slip", 32'(slip), 32'd0);
        reset = 1'b0;
        repeat (12) tick();
        check("rst_mid_noframe", 32'(hs_cyc.size() - frames_at_rst), 32'd0);

        // Slip: orphan left sample dropped TO cycles after POP_PW is entered.
        nw_q.push_back(16'h0001);
        n = 0;
        while (!nw_fifo_rd_en && n < 20) begin
            tick();
            n++;
        end
        n = 0;
        while (!slip && n < 40) begin
            tick();
            n++;
        end
        check("slip_delay", 32'(n), 32'(TO + 2));
        tick();
        check("slip_width", 32'(slip), 32'd0);
        check("slip_pulses", 32'(n_slip - slip_at_rst), 32'd1);
        pw_q.push_back(16'h0002);
        nw_q.push_back(16'h0003);
        exp_q.push_back(32'h0003_0002);
        wait_drain(30);
        check("slip_resync", 32'(n_slip - slip_at_rst), 32'd1);

        // Stray rd_valid pulses while idle must not disturb pairing.
        inj_pw_req++;
        repeat (3) tick();
        inj_nw_req++;
        repeat (3) tick();
        push_pair(16'h7E57, 16'h1111);
        wait_drain(30);

        // Random traffic with random backpressure.
        for (int i = 0; i < 40; i++) begin
            l = 16'($urandom);
            push_pair(l, 16'($urandom));
            repeat ($urandom_range(0, 6)) begin
                frame_ready = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        frame_ready = 1'b1;
        wait_drain(800);
        check("final_slips", 32'(n_slip - slip_at_rst), 32'd1);

`ifdef AIC3204_FRAME_STATS_EN
        check("stat_frames", 32'(frame_count), 32'(hs_cyc.size() - frames_at_rst));
        check("stat_slips", 32'(slip_count), 32'd1);
        check("stat_strays", 32'(stray_count), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aic3204_frame_pack.md
# aic3204_frame_pack

Pairs the two per-channel 16-bit sample streams that `aic3204_if` delivers on its nw (left, WCLK low) and pw (right, WCLK high) read FIFOs into 32-bit stereo frames. Frames leave on a valid/ready stream for downstream DSP. The block sits directly downstream of `aic3204_if` in the `clk` domain and owns both read-FIFO handshakes. It detects channel slip, where one FIFO starves while the other holds a sample, and resynchronises by dropping the orphan sample.

## Interface
- `SLIP_TIMEOUT`, default 256: cycles an nw sample may wait for its pw partner before it is dropped; legal range 2..65535.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `nw_fifo_rd_data` in 16: left sample, two's complement.
- `nw_fifo_rd_valid` in 1: data valid, exactly 1 cycle after an accepted `nw_fifo_rd_en`.
- `nw_fifo_rd_en` out 1: pop request.
- `nw_fifo_empty` in 1: nw FIFO empty.
- `pw_fifo_rd_data` / `pw_fifo_rd_valid` / `pw_fifo_rd_en` / `pw_fifo_empty`: same as the nw ports, for the right channel.
- `frame_data` out 32: `{left[15:0], right[15:0]}`.
- `frame_valid` out 1: frame available.
- `frame_ready` in 1: downstream accepts.
- `slip` out 1: one-cycle pulse when an orphan nw sample is dropped.

## Operation
- FSM states: IDLE, POP_NW, WAIT_NW, POP_PW, WAIT_PW, HOLD.
- IDLE: if `!nw_fifo_empty`, go to POP_NW.
- POP_NW: assert `nw_fifo_rd_en` for exactly 1 cycle, then go to WAIT_NW.
- WAIT_NW: on `nw_fifo_rd_valid`, latch the left sample, clear the slip counter, go to POP_PW. If no `rd_valid` arrives within 1 cycle, treat it as a protocol error and return to IDLE. No pulse is generated.
- POP_PW:
  - If `!pw_fifo_empty`, assert `pw_fifo_rd_en` for 1 cycle and go to WAIT_PW.
  - Otherwise increment the slip counter.
  - When the counter reaches `SLIP_TIMEOUT-1`, pulse `slip`, discard the left sample, go to IDLE.
- WAIT_PW: on `pw_fifo_rd_valid`, latch the right sample into `frame_data`, set `frame_valid`, go to HOLD.
- HOLD: when `frame_valid && frame_ready`, clear `frame_valid`.
  - If `!nw_fifo_empty` in that same cycle, go directly to POP_NW (back-to-back).
  - Otherwise go to IDLE.
- Output rules:
  - `frame_data` is stable while `frame_valid=1` and `frame_ready=0`.
  - `frame_valid` never drops without a handshake.
- `rd_en` rules:
  - `rd_en` is never asserted while the corresponding `empty=1`.
  - At most one outstanding pop per FIFO.
- A `rd_valid` arriving in any state other than its WAIT state is ignored. In STATS builds it is counted as stray.
- Reset mid-frame: any latched sample is discarded. No partial frame is ever emitted.

## Timing
- Reset values: `nw_fifo_rd_en=0`, `pw_fifo_rd_en=0`, `frame_valid=0`, `frame_data=0`, `slip=0`, state IDLE, slip counter 0.
- Latency: both FIFOs non-empty at IDLE gives `frame_valid` 5 cycles later (POP_NW, WAIT_NW, POP_PW, WAIT_PW, then registered valid).
- Throughput: one frame per 5 cycles with `frame_ready` tied high. This is far above the audio rate.
- `slip` is asserted in the cycle after the counter reaches `SLIP_TIMEOUT-1`.
- The FSM is in IDLE on the next cycle after that pulse.

## Configuration
- `AIC3204_FRAME_STATS_EN` defined: adds three outputs, each 16 bits, saturating, cleared by `reset`:
  - `frame_count`: incremented per handshake.
  - `slip_count`: incremented per `slip` pulse.
  - `stray_count`: incremented per ignored `rd_valid`.
- `AIC3204_FRAME_STATS_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package `aic3204_pkg`:
  - `sample_t` (logic signed [15:0]).
  - `frame_t` (packed struct {left, right}).
  - FSM state enum `frame_state_e`.
  - Constant `AIC3204_SAMPLE_W=16`.
- One sub-module, `aic3204_slip_timer`: loadable count-up counter with a terminal-count pulse. It is parameterised by `SLIP_TIMEOUT` and instantiated once.

## Test plan
- Pre-load nw={0x1234}, pw={0xABCD}, `frame_ready=1` -> `frame_data=0x1234ABCD`, `frame_valid` high for 1 cycle, 5 cycles after reset release; no `slip`.
- Stream 8 pairs, left=n, right=0x8000+n -> 8 frames in order, one per 5 cycles, each `{n, 0x8000+n}`.
- `frame_ready=0` for 20 cycles with a frame pending -> `frame_data` and `frame_valid` held constant, no further `rd_en`; releasing ready completes the handshake, then the next pop starts.
- nw={0x0001}, pw empty, `SLIP_TIMEOUT=4` -> `slip` pulses once about 4 cycles into POP_PW. Then load pw={0x0002}, nw={0x0003} -> frame 0x00030002.
- Assert `reset` in WAIT_PW after the left sample is latched -> all outputs at reset values next cycle, no frame emitted.
- STATS build: 3 frames plus 1 slip plus 1 injected stray `rd_valid` -> `frame_count=3`, `slip_count=1`, `stray_count=1`.
